// File: rtl/proc_pkg.sv
// proc_pkg: opcode/state enums and instruction field widths shared by the multi-cycle core
package proc_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LD, OP_ST, OP_BNZ, OP_HALT
  } opcode_e;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_e;
  localparam int OP_W = 3;
  localparam int OP_FROM_TOP = 1;
endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: 2**RAW x DW register file, two async read ports, one sync write port
module proc_regfile
  import proc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int RAW = 3
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_we,
  input  logic [RAW-1:0] i_waddr,
  input  logic [DW-1:0]  i_wdata,
  input  logic [RAW-1:0] i_raddr_a,
  input  logic [RAW-1:0] i_raddr_b,
  output logic [DW-1:0]  o_rdata_a,
  output logic [DW-1:0]  o_rdata_b
);
  logic [DW-1:0] r_regs [2**RAW];
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_regs <= '{default: '0};
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
endmodule

// File: rtl/proc_core_mc.sv
// proc_core_mc: multi-cycle FETCH/DECODE/EXEC/MEM/WB core with Start/Ack handshake,
// cycle/retire counters and a per-run watchdog
module proc_core_mc
  import proc_pkg::*;
#(
  parameter int          DW      = 8,
  parameter int          PCW     = 10,
  parameter int          RAW     = 3,
  parameter int          IW      = OP_W + 2*RAW,
  parameter logic [31:0] MAX_CYC = 32'hFFFF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  output logic           o_ack,
  output logic           o_busy,
  output logic           o_timeout,
  output logic [31:0]    o_cycle_ct,
  output logic [31:0]    o_inst_ct,
  output logic [PCW-1:0] o_imem_addr,
  input  logic [IW-1:0]  i_imem_data,
  output logic [DW-1:0]  o_dmem_addr,
  output logic [DW-1:0]  o_dmem_wdata,
  output logic           o_dmem_we,
  input  logic [DW-1:0]  i_dmem_rdata
);
  state_e         r_state;
  opcode_e        r_op;
  logic [RAW-1:0] r_wa;
  logic [PCW-1:0] r_pc;
  logic [DW-1:0]  r_a, r_b;
  opcode_e        w_dec_op;
  logic [DW-1:0]  w_ra_val, w_rb_val, w_alu, w_wdata;
  logic [PCW-1:0] w_off;
  logic           w_wdog, w_retire, w_rf_we;
  assign w_dec_op = opcode_e'(i_imem_data[IW-1 -: OP_W]);
  assign w_off    = PCW'($signed(r_b));
  assign w_wdog   = o_busy && (o_cycle_ct == MAX_CYC - 32'd1);
  always_comb begin
    w_alu = r_op == OP_ADD ? r_a + r_b :
            r_op == OP_SUB ? r_a - r_b :
            r_op == OP_AND ? r_a & r_b : r_a ^ r_b;
    w_wdata = r_op == OP_LD ? i_dmem_rdata : w_alu;
    w_rf_we = r_state == S_WB && !w_wdog;
    w_retire = r_state == S_WB || (r_state == S_MEM && r_op == OP_ST) ||
               (r_state == S_EXEC && r_op == OP_BNZ) || (r_state == S_DECODE && w_dec_op == OP_HALT);
  end
  // an instruction caught by the watchdog must leave no memory side effect
  assign o_dmem_we    = r_state == S_MEM && r_op == OP_ST && !w_wdog;
  assign o_dmem_addr  = r_b;
  assign o_dmem_wdata = r_a;
  proc_regfile #(.DW(DW), .RAW(RAW)) u_rf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (w_rf_we),
    .i_waddr   (r_wa),
    .i_wdata   (w_wdata),
    .i_raddr_a (i_imem_data[2*RAW-1 -: RAW]),
    .i_raddr_b (i_imem_data[RAW-1:0]),
    .o_rdata_a (w_ra_val),
    .o_rdata_b (w_rb_val)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_wa        <= '0;
      r_pc        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      o_ack       <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_cycle_ct  <= '0;
      o_inst_ct   <= '0;
      o_imem_addr <= '0;
    end else if (w_wdog) begin
      r_state    <= S_DONE;
      o_busy     <= 1'b0;
      o_ack      <= 1'b1;
      o_timeout  <= 1'b1;
      o_cycle_ct <= o_cycle_ct + 32'd1;
    end else begin
      if (o_busy) o_cycle_ct <= o_cycle_ct + 32'd1;
      if (w_retire) o_inst_ct <= o_inst_ct + 32'd1;
      case (r_state)
        S_IDLE, S_DONE:
          if (i_start) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            o_cycle_ct <= '0;
            o_inst_ct  <= '0;
            o_timeout  <= 1'b0;
            o_ack      <= 1'b0;
            o_busy     <= 1'b1;
          end
        S_FETCH: begin
          o_imem_addr <= r_pc;
          r_state     <= S_DECODE;
        end
        S_DECODE: begin
          r_op <= w_dec_op;
          r_wa <= i_imem_data[2*RAW-1 -: RAW];
          r_a  <= w_ra_val;
          r_b  <= w_rb_val;
          if (w_dec_op == OP_HALT) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_ack   <= 1'b1;
          end else r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_pc    <= (r_op == OP_BNZ && r_a != '0) ? r_pc + w_off : r_pc + PCW'(1);
          r_state <= r_op == OP_BNZ ? S_FETCH : (r_op == OP_LD || r_op == OP_ST) ? S_MEM : S_WB;
        end
        S_MEM:   r_state <= r_op == OP_LD ? S_WB : S_FETCH;
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule
